// File: rtl/sad_tree_accum.sv
// ============================================================================
// Module   : sad_tree_accum
// Purpose  : Sum-of-absolute-differences engine for block motion search.
//            Each beat carries LANES pixel pairs. A registered absolute-
//            difference stage feeds a LG-level registered adder tree, and
//            the tree output is accumulated over BEATS beats to form one
//            block SAD. Completed SADs are tagged with a candidate index
//            that advances after every block.
// Optional : `define SAD_MIN_TRACK_EN to keep the minimum SAD (and its
//            index) seen since the last search_start. When the macro is
//            undefined, best_sad and best_idx are tied to zero and the
//            comparator and best registers are not built.
// Ports    : clk          - rising-edge clock
//            rst          - synchronous active-high reset
//            in_valid     - beat qualifier, no backpressure
//            in_a, in_b   - current / reference pixels, lane k at [k*PIX_W +: PIX_W]
//            search_start - restarts candidate index, beat count and best tracking
//            sad_valid    - one-cycle pulse when a block SAD completes
//            sad_out      - block SAD, held until the next sad_valid
//            sad_idx      - candidate index of sad_out
//            best_sad     - minimum SAD since search_start (optional feature)
//            best_idx     - candidate index of best_sad (optional feature)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sad_tree_accum #(
   parameter  int LANES = 16,
   parameter  int PIX_W = 8,
   parameter  int BEATS = 16,
   parameter  int IDX_W = 8,
   localparam int LG    = $clog2(LANES),
   localparam int LB    = $clog2(BEATS),
   localparam int SAD_W = PIX_W + LG + LB
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [LANES*PIX_W-1:0] in_a,
   input  logic [LANES*PIX_W-1:0] in_b,
   input  logic                   search_start,
   output logic                   sad_valid,
   output logic [SAD_W-1:0]       sad_out,
   output logic [IDX_W-1:0]       sad_idx,
   output logic [SAD_W-1:0]       best_sad,
   output logic [IDX_W-1:0]       best_idx
);

   typedef logic [SAD_W-1:0] sad_t;

   // The beat counter needs at least one bit even when BEATS is 1.
   localparam int                CNT_W     = (LB > 0) ? LB : 1;
   localparam logic [CNT_W-1:0]  LAST_BEAT = CNT_W'(BEATS - 1);

   // -------------------------------------------------------------------------
   // Difference stage (s = 0) and adder tree (s = 1..LG). Stage s holds
   // LANES >> s partial sums of PIX_W + s bits, so no carry is ever lost.
   // The valid bit travels alongside; search_start drops every beat already
   // inside the tree but still admits the beat presented on that same cycle.
   // -------------------------------------------------------------------------
   for (genvar s = 0; s <= LG; s++) begin : g_stage
      localparam int N = LANES >> s;
      localparam int W = PIX_W + s;

      logic [W-1:0] sum_q [N];
      logic [W-1:0] sum_d [N];
      logic         vld_q;
      logic         vld_d;

      if (s == 0) begin : g_diff
         always_comb begin
            for (int k = 0; k < N; k++) begin
               sum_d[k] = (in_a[k*PIX_W +: PIX_W] > in_b[k*PIX_W +: PIX_W])
                        ? (in_a[k*PIX_W +: PIX_W] - in_b[k*PIX_W +: PIX_W])
                        : (in_b[k*PIX_W +: PIX_W] - in_a[k*PIX_W +: PIX_W]);
            end
            vld_d = in_valid;
         end
      end else begin : g_add
         always_comb begin
            for (int k = 0; k < N; k++) begin
               sum_d[k] = {1'b0, g_stage[s-1].sum_q[2*k]}
                        + {1'b0, g_stage[s-1].sum_q[2*k+1]};
            end
            vld_d = g_stage[s-1].vld_q && !search_start;
         end
      end

      always_ff @(posedge clk) begin
         if (rst) begin
            vld_q <= 1'b0;
         end else begin
            vld_q <= vld_d;
         end
         sum_q <= sum_d;
      end
   end

   // -------------------------------------------------------------------------
   // Block accumulator at the tree output
   // -------------------------------------------------------------------------
   logic             tree_vld;
   sad_t             tree_sum;
   sad_t             blk_sum;
   logic             blk_done;

   sad_t             acc_q,       acc_d;
   logic [CNT_W-1:0] beat_q,      beat_d;
   logic [IDX_W-1:0] cand_q,      cand_d;
   logic             sad_valid_q, sad_valid_d;
   sad_t             sad_out_q,   sad_out_d;
   logic [IDX_W-1:0] sad_idx_q,   sad_idx_d;

   always_comb begin
      tree_vld = g_stage[LG].vld_q;
      tree_sum = sad_t'(g_stage[LG].sum_q[0]);
      // First beat of a block loads rather than adds, so the accumulator
      // never needs an explicit clear between blocks.
      blk_sum  = (beat_q == '0) ? tree_sum : (acc_q + tree_sum);
      blk_done = tree_vld && (beat_q == LAST_BEAT) && !search_start;

      acc_d       = acc_q;
      beat_d      = beat_q;
      cand_d      = cand_q;
      sad_valid_d = 1'b0;
      sad_out_d   = sad_out_q;
      sad_idx_d   = sad_idx_q;

      if (search_start) begin
         acc_d  = '0;
         beat_d = '0;
         cand_d = '0;
      end else if (tree_vld) begin
         acc_d  = blk_sum;
         beat_d = blk_done ? '0 : (beat_q + CNT_W'(1));
         if (blk_done) begin
            sad_valid_d = 1'b1;
            sad_out_d   = blk_sum;
            sad_idx_d   = cand_q;
            cand_d      = cand_q + IDX_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         beat_q      <= '0;
         cand_q      <= '0;
         sad_valid_q <= 1'b0;
         sad_out_q   <= '0;
         sad_idx_q   <= '0;
      end else begin
         acc_q       <= acc_d;
         beat_q      <= beat_d;
         cand_q      <= cand_d;
         sad_valid_q <= sad_valid_d;
         sad_out_q   <= sad_out_d;
         sad_idx_q   <= sad_idx_d;
      end
   end

   assign sad_valid = sad_valid_q;
   assign sad_out   = sad_out_q;
   assign sad_idx   = sad_idx_q;

   // -------------------------------------------------------------------------
   // Optional minimum tracking. Only a strictly smaller SAD replaces the
   // current best, so ties keep the earlier candidate. The best registers
   // update on the same edge that raises sad_valid.
   // -------------------------------------------------------------------------
`ifdef SAD_MIN_TRACK_EN
   sad_t             best_sad_q, best_sad_d;
   logic [IDX_W-1:0] best_idx_q, best_idx_d;

   always_comb begin
      best_sad_d = best_sad_q;
      best_idx_d = best_idx_q;
      if (search_start) begin
         best_sad_d = '1;
         best_idx_d = '0;
      end else if (blk_done && (blk_sum < best_sad_q)) begin
         best_sad_d = blk_sum;
         best_idx_d = cand_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         best_sad_q <= '1;
         best_idx_q <= '0;
      end else begin
         best_sad_q <= best_sad_d;
         best_idx_q <= best_idx_d;
      end
   end

   assign best_sad = best_sad_q;
   assign best_idx = best_idx_q;
`else
   assign best_sad = '0;
   assign best_idx = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_sad_tree_accum.sv
// ============================================================================
// Module   : tb_sad_tree_accum
// Purpose  : Self-checking bench for sad_tree_accum. A transaction-level
//            model collects accepted beats into blocks and schedules the
//            expected SAD results; a compare process checks every DUT output
//            on every cycle. Directed sequences pin known literal results,
//            and a second instance (LANES=4, BEATS=1) covers the
//            single-beat configuration.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sad_tree_accum;

   localparam int LANES = 16;
   localparam int PIX_W = 8;
   localparam int BEATS = 16;
   localparam int IDX_W = 8;
   localparam int LG    = 4;
   localparam int SAD_W = 16;
   localparam int VW    = LANES * PIX_W;
`ifdef SAD_MIN_TRACK_EN
   localparam longint BEST_RST = 65535;
`else
   localparam longint BEST_RST = 0;
`endif

   logic             clk          = 1'b0;
   logic             rst          = 1'b1;
   logic             in_valid     = 1'b0;
   logic             search_start = 1'b0;
   logic [VW-1:0]    in_a         = '0;
   logic [VW-1:0]    in_b         = '0;
   logic             sad_valid;
   logic [SAD_W-1:0] sad_out;
   logic [IDX_W-1:0] sad_idx;
   logic [SAD_W-1:0] best_sad;
   logic [IDX_W-1:0] best_idx;

   // second instance: LANES=4, BEATS=1 -> SAD_W = 8 + 2 + 0 = 10
   logic             in1_valid = 1'b0;
   logic             ss1       = 1'b0;
   logic [31:0]      in1_a     = '0;
   logic [31:0]      in1_b     = '0;
   logic             sad1_valid;
   logic [9:0]       sad1_out;
   logic [7:0]       sad1_idx;
   logic [9:0]       best1_sad;
   logic [7:0]       best1_idx;

   always #5 clk = ~clk;

   sad_tree_accum #(.LANES(LANES), .PIX_W(PIX_W), .BEATS(BEATS), .IDX_W(IDX_W)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_a(in_a), .in_b(in_b),
      .search_start(search_start), .sad_valid(sad_valid), .sad_out(sad_out),
      .sad_idx(sad_idx), .best_sad(best_sad), .best_idx(best_idx)
   );

   sad_tree_accum #(.LANES(4), .PIX_W(8), .BEATS(1), .IDX_W(8)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(in1_valid), .in_a(in1_a), .in_b(in1_b),
      .search_start(ss1), .sad_valid(sad1_valid), .sad_out(sad1_out),
      .sad_idx(sad1_idx), .best_sad(best1_sad), .best_idx(best1_idx)
   );

   int n_cmp   = 0;
   int n_bad   = 0;
   int obs_cnt = 0;
   bit started = 1'b0;

   task automatic chk(input string nm, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [VW-1:0] rep(input logic [7:0] v);
      logic [VW-1:0] r;
      for (int k = 0; k < LANES; k++) r[k*8 +: 8] = v;
      return r;
   endfunction

   function automatic longint beat_sum(input logic [VW-1:0] a, input logic [VW-1:0] b);
      longint s = 0;
      for (int k = 0; k < LANES; k++) begin
         int x = int'(a[k*8 +: 8]);
         int y = int'(b[k*8 +: 8]);
         s += (x > y) ? longint'(x - y) : longint'(y - x);
      end
      return s;
   endfunction

   // -------------------------------------------------------------------------
   // Reference model: every accepted beat adds its SAD to the open block;
   // the BEATS-th beat closes the block and schedules its result LG+1 edges
   // later. Reset or search_start throws away the open block and any result
   // not yet presented.
   // -------------------------------------------------------------------------
   typedef struct {
      int     due;
      longint sad;
      int     idx;
   } blk_t;

   blk_t   q[$];
   int     edge_n   = 0;
   longint part     = 0;
   int     nb       = 0;
   int     mcand    = 0;
   bit     exp_valid = 1'b0;
   longint exp_sad  = 0;
   longint exp_idx  = 0;
   longint exp_best = BEST_RST;
   longint exp_bidx = 0;

   initial begin
      forever begin
         @(posedge clk);
         edge_n++;
         exp_valid = 1'b0;
         if (rst) begin
            q.delete();
            part = 0; nb = 0; mcand = 0;
            exp_sad = 0; exp_idx = 0;
            exp_best = BEST_RST; exp_bidx = 0;
            started = 1'b1;
         end else begin
            if (search_start) begin
               q.delete();
               part = 0; nb = 0; mcand = 0;
               exp_best = BEST_RST; exp_bidx = 0;
            end else if (q.size() > 0 && q[0].due == edge_n) begin
               exp_valid = 1'b1;
               exp_sad   = q[0].sad;
               exp_idx   = q[0].idx;
`ifdef SAD_MIN_TRACK_EN
               if (q[0].sad < exp_best) begin
                  exp_best = q[0].sad;
                  exp_bidx = q[0].idx;
               end
`endif
               void'(q.pop_front());
            end
            if (in_valid) begin
               part += beat_sum(in_a, in_b);
               nb++;
               if (nb == BEATS) begin
                  q.push_back('{due: edge_n + LG + 1, sad: part, idx: mcand});
                  mcand = (mcand + 1) % 256;
                  part  = 0;
                  nb    = 0;
               end
            end
         end
      end
   end

   // Compare process: all outputs of the main instance, every cycle.
   initial begin
      forever begin
         @(negedge clk);
         if (started) begin
            chk("sad_valid", longint'(sad_valid), longint'(exp_valid));
            chk("sad_out",   longint'(sad_out),   exp_sad);
            chk("sad_idx",   longint'(sad_idx),   exp_idx);
            chk("best_sad",  longint'(best_sad),  exp_best);
            chk("best_idx",  longint'(best_idx),  exp_bidx);
            if (sad_valid) obs_cnt++;
         end
      end
   end

   // -------------------------------------------------------------------------
   // Stimulus helpers
   // -------------------------------------------------------------------------
   task automatic beat(input logic v, input logic [VW-1:0] a, input logic [VW-1:0] b,
                       input logic ss);
      in_valid     = v;
      in_a         = a;
      in_b         = b;
      search_start = ss;
      @(negedge clk);
      in_valid     = 1'b0;
      search_start = 1'b0;
   endtask

   // Idles the inputs and waits for the next sad_valid, reporting latency as
   // cycles counted from the accepting cycle of the last beat.
   task automatic wait_sad(input string nm, input int exp_lat, input longint exp_s,
                           input longint exp_i);
      int n = -2;
      for (int i = 1; i <= 40; i++) begin
         @(negedge clk);
         if (sad_valid) begin
            n = i;
            break;
         end
      end
      chk({nm, " latency"}, longint'(n + 1), longint'(exp_lat));
      chk({nm, " sad_out"}, longint'(sad_out), exp_s);
      chk({nm, " sad_idx"}, longint'(sad_idx), exp_i);
   endtask

   task automatic wait_sad1(input string nm, input longint exp_s, input longint exp_i);
      int n = -2;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         if (sad1_valid) begin
            n = i;
            break;
         end
      end
      chk({nm, " latency"}, longint'(n + 1), 4);
      chk({nm, " sad_out"}, longint'(sad1_out), exp_s);
      chk({nm, " sad_idx"}, longint'(sad1_idx), exp_i);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [VW-1:0] va;
      logic [VW-1:0] vb;
      logic          v;
      logic          ss;
      int            obs0;
      int            mode;
      int            sads [3];

      sads = '{500, 300, 300};

      repeat (3) @(negedge clk);
      rst = 1'b0;
      chk("reset sad_valid", longint'(sad_valid), 0);
      chk("reset sad_out",   longint'(sad_out),   0);
      chk("reset sad_idx",   longint'(sad_idx),   0);
      chk("reset best_sad",  longint'(best_sad),  BEST_RST);
      chk("reset best_idx",  longint'(best_idx),  0);

      // A: full-scale differences, back-to-back beats
      for (int i = 0; i < 16; i++) beat(1'b1, rep(8'hFF), rep(8'h00), 1'b0);
      wait_sad("A", 6, 65280, 0);

      // B: lane k difference = k, idle cycle between beats
      for (int k = 0; k < LANES; k++) va[k*8 +: 8] = 8'(k);
      for (int i = 0; i < 16; i++) begin
         if (i > 0) beat(1'b0, '0, '0, 1'b0);
         beat(1'b1, va, '0, 1'b0);
      end
      wait_sad("B", 6, 1920, 1);

      // C: reset part-way through a block (reset also dominates valid/start)
      for (int i = 0; i < 8; i++) begin
         for (int k = 0; k < LANES; k++) begin
            va[k*8 +: 8] = 8'($urandom);
            vb[k*8 +: 8] = 8'($urandom);
         end
         beat(1'b1, va, vb, 1'b0);
      end
      rst = 1'b1;
      beat(1'b1, rep(8'h09), rep(8'h00), 1'b1);
      rst = 1'b0;
      chk("C post-reset sad_out", longint'(sad_out), 0);
      chk("C post-reset sad_idx", longint'(sad_idx), 0);
      for (int i = 0; i < 16; i++) beat(1'b1, rep(8'h01), rep(8'h00), 1'b0);
      wait_sad("C", 6, 256, 0);

      // D: search_start on the fifth beat restarts the block there
      for (int i = 0; i < 4; i++) beat(1'b1, rep(8'h03), rep(8'h00), 1'b0);
      beat(1'b1, rep(8'h02), rep(8'h00), 1'b1);
      chk("D best_sad after start", longint'(best_sad), BEST_RST);
      chk("D best_idx after start", longint'(best_idx), 0);
      for (int i = 0; i < 15; i++) beat(1'b1, rep(8'h02), rep(8'h00), 1'b0);
      wait_sad("D", 6, 512, 0);

      // E: three back-to-back blocks with SADs 500, 300, 300
      obs0 = obs_cnt;
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 16; i++) begin
            va = '0;
            if (i == 0) begin
               va[7:0]  = 8'hFF;
               va[15:8] = 8'(sads[b] - 255);
            end
            beat(1'b1, va, '0, (b == 0 && i == 0) ? 1'b1 : 1'b0);
         end
      end
      repeat (10) beat(1'b0, '0, '0, 1'b0);
      chk("E sad_valid count", longint'(obs_cnt - obs0), 3);
      chk("E last sad_out",    longint'(sad_out), 300);
      chk("E last sad_idx",    longint'(sad_idx), 2);
`ifdef SAD_MIN_TRACK_EN
      chk("E best_sad", longint'(best_sad), 300);
      chk("E best_idx", longint'(best_idx), 1);
`else
      chk("E best_sad tied", longint'(best_sad), 0);
      chk("E best_idx tied", longint'(best_idx), 0);
`endif

      // F: single-beat blocks on the LANES=4 instance
      in1_valid = 1'b1; in1_a = 32'hFFFF_FFFF; in1_b = 32'h0;
      @(negedge clk);
      in1_valid = 1'b0;
      wait_sad1("F0", 1020, 0);
      in1_valid = 1'b1; in1_a = 32'h0403_0201; in1_b = 32'h0;
      @(negedge clk);
      in1_valid = 1'b0;
      wait_sad1("F1", 10, 1);

      // Random traffic: alternating full-rate, dense and sparse phases with
      // occasional search_start and reset.
      for (int c = 0; c < 4000; c++) begin
         mode = (c / 250) % 3;
         case (mode)
            0:       v = 1'b1;
            1:       v = ($urandom_range(0, 9) < 7);
            default: v = ($urandom_range(0, 9) < 3);
         endcase
         for (int k = 0; k < LANES; k++) begin
            va[k*8 +: 8] = 8'($urandom);
            vb[k*8 +: 8] = (mode == 2) ? (va[k*8 +: 8] ^ 8'($urandom_range(0, 7)))
                                       : 8'($urandom);
         end
         ss  = ($urandom_range(0, 399) == 0);
         rst = ($urandom_range(0, 999) == 0);
         beat(v, va, vb, ss);
         rst = 1'b0;
      end
      repeat (20) beat(1'b0, '0, '0, 1'b0);
      chk("drain pending results", longint'(q.size()), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/sad_tree_accum.md
SAD_TREE_ACCUM -- requirements
Module: sad_tree_accum

Interface
REQ-001 Parameter LANES, default 16: pixel lanes per beat; power of two, 2..64.
REQ-002 Parameter PIX_W, default 8: unsigned pixel width.
REQ-003 Parameter BEATS, default 16: beats per block; power of two, 1..256.
REQ-004 Parameter IDX_W, default 8: candidate index width.
REQ-005 Derived: LG=log2(LANES), LB=log2(BEATS), SAD_W=PIX_W+LG+LB.
REQ-006 Clk  in  1  single clock, all logic rising-edge.
REQ-007 Reset  in  1  synchronous, active-high.
REQ-008 in_valid  in  1  beat qualifier; no backpressure, accepted every cycle it is high.
REQ-009 in_a  in  LANES*PIX_W  current pixels, lane k at bits [k*PIX_W +: PIX_W].
REQ-010 in_b  in  LANES*PIX_W  reference pixels, same packing.
REQ-011 search_start  in  1  pulse; restarts candidate index and best tracking.
REQ-012 sad_valid  out  1  one-cycle pulse, block SAD ready.
REQ-013 sad_out  out  SAD_W  block SAD, held until next sad_valid.
REQ-014 sad_idx  out  IDX_W  candidate index of sad_out.
REQ-015 best_sad  out  SAD_W  minimum SAD since search_start (MIN_TRACK_EN only).
REQ-016 best_idx  out  IDX_W  index of best_sad (MIN_TRACK_EN only).

Function
REQ-017 Stage 0 SHALL register per-lane |in_a-in_b| (PIX_W bits) with a valid bit when in_valid=1.
REQ-018 LG registered adder stages SHALL halve the lane count per stage, each stage widening by 1 bit; no truncation.
REQ-019 Valid bits SHALL travel with data; stages whose valid is 0 SHALL not affect the accumulator.
REQ-020 Tree-output valid SHALL appear exactly LG+1 cycles after the accepting in_valid cycle.
REQ-021 Accumulator (SAD_W bits) SHALL load the tree sum on the first beat of a block and add on subsequent beats.
REQ-022 A beat counter (LB bits) at tree output SHALL count valid beats and wrap to 0 after BEATS-1.
REQ-023 On the BEATS-th beat, sad_out SHALL be updated and sad_valid pulsed the next cycle: LG+2 cycles after the last beat accepted.
REQ-024 Gaps in in_valid SHALL be allowed anywhere; partial blocks SHALL persist until completed.
REQ-025 Back-to-back blocks at full rate SHALL produce sad_valid every BEATS cycles with no lost beat.
REQ-026 sad_idx SHALL equal the candidate counter value, which increments (wrapping mod 2^IDX_W) after each sad_valid.
REQ-027 search_start SHALL zero candidate counter, beat counter, accumulator and flush in-flight valid bits in the same edge; beats accepted on that cycle SHALL count as beat 0 of candidate 0.
REQ-028 BEATS=1: every valid tree output SHALL produce a sad_valid.

Reset
REQ-029 Reset SHALL clear all valid bits, beat counter, candidate counter and accumulator.
REQ-030 Reset values: sad_valid=0, sad_out=0, sad_idx=0, best_sad=all ones, best_idx=0.
REQ-031 Reset mid-block SHALL discard the partial block; no sad_valid until BEATS new beats complete.
REQ-032 Reset SHALL dominate search_start and in_valid on the same cycle.

Configuration
REQ-033 Macro SAD_MIN_TRACK_EN defined: compare each completed SAD with best_sad; strictly smaller replaces best_sad/best_idx in the sad_valid cycle; ties keep the earlier index.
REQ-034 search_start SHALL set best_sad to all ones, best_idx to 0; a block completing on the same cycle SHALL be discarded.
REQ-035 Macro undefined: comparator and best registers SHALL be absent; best_sad and best_idx SHALL be tied to 0.

Verification
REQ-036 LANES=16, PIX_W=8, BEATS=16; all a=255, b=0 for 16 consecutive beats -> one sad_valid 6 cycles after last beat, sad_out=65280, sad_idx=0.
REQ-037 Lane k a=k, b=0, 16 beats with in_valid low every other cycle -> sad_out=1920; no sad_valid before beat 16.
REQ-038 Three back-to-back blocks giving SADs 500, 300, 300 with SAD_MIN_TRACK_EN -> sad_idx 0,1,2; best_sad=300, best_idx=1.
REQ-039 Reset asserted after beat 8 of a block, then 16 beats of |diff|=1 -> single sad_valid, sad_out=256.
REQ-040 search_start on cycle of beat 5 -> that beat is beat 0 of candidate 0; sad_valid after 15 more beats, best_sad starts from all ones (65535).
REQ-041 BEATS=1, LANES=4, PIX_W=8; one beat all diffs 255 -> sad_out=1020, sad_valid 4 cycles after acceptance.
